// File: rtl/fixed_qrot_if.sv
`default_nettype none
// ============================================================================
// Module   : fixed_qrot_if
// Brief    : Input/output handshake bundle for the fixed-point quaternion rotator.
// Revision : 1.0 - initial release
// ============================================================================
interface fixed_qrot_if #(
    parameter int TOTAL_PREC = 18
);
    logic                         in_valid;
    logic                         in_ready;
    logic signed [TOTAL_PREC-1:0] q   [4];
    logic signed [TOTAL_PREC-1:0] v   [3];
    logic                         out_valid;
    logic                         out_ready;
    logic signed [TOTAL_PREC-1:0] res [3];

    // master = environment driving operands and taking results; slave = rotator
    modport master (
        output in_valid, q, v, out_ready,
        input  in_ready, out_valid, res
    );
    modport slave (
        input  in_valid, q, v, out_ready,
        output in_ready, out_valid, res
    );
endinterface
`default_nettype wire

// File: rtl/fixed_qrot.sv
`default_nettype none
// ============================================================================
// Module   : fixed_qrot
// Brief    : Sequential v' = q*v*q^-1 rotator, one shared multiplier, 16-cycle
//            latency. Define FIXED_QROT_SAT_EN to saturate results instead of wrap.
// Revision : 1.0 - initial release
// ============================================================================
module fixed_qrot #(
    parameter int TOTAL_PREC = 18,
    parameter int FRAC_BITS  = 13
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    fixed_qrot_if.slave bus,
    output logic        busy
);
    localparam int TW = TOTAL_PREC + 2;
    localparam int AW = TOTAL_PREC + 4;
    localparam int PW = 2 * TW;
`ifdef FIXED_QROT_SAT_EN
    localparam logic signed [AW-1:0] RES_MAX = AW'(2 ** (TOTAL_PREC - 1) - 1);
    localparam logic signed [AW-1:0] RES_MIN = -RES_MAX - AW'(1);
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_T    = 2'd1,
        S_R    = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                       state;
    logic [3:0]                   step;
    logic signed [TOTAL_PREC-1:0] u_r     [3];
    logic signed [TOTAL_PREC-1:0] v_r     [3];
    logic signed [TOTAL_PREC-1:0] w_r;
    logic signed [TW-1:0]         t_r     [3];
    logic signed [PW-1:0]         hold_r;
    logic signed [AW-1:0]         acc_r;
    logic signed [TOTAL_PREC-1:0] stage_r [2];
    logic signed [TOTAL_PREC-1:0] res_r   [3];
    logic                         in_ready_r;
    logic                         out_valid_r;

    logic [1:0]                   a_sel;
    logic [1:0]                   b_sel;
    logic [1:0]                   comp;
    logic [1:0]                   kind;
    logic signed [TW-1:0]         op_a;
    logic signed [TW-1:0]         op_b;
    logic signed [PW-1:0]         prod;
    logic signed [PW-1:0]         prod_sh;
    logic signed [TW-1:0]         t_new;
    logic signed [AW-1:0]         v_pre;
    logic signed [AW-1:0]         addend;
    logic signed [AW-1:0]         sum;
    logic signed [TOTAL_PREC-1:0] narrowed;

    // Schedule: a_sel 3 selects w; in T the b operand comes from v, in R from t.
    always_comb begin
        a_sel = 2'd0;
        b_sel = 2'd0;
        comp  = 2'd0;
        kind  = 2'd0;
        if (state == S_T) begin
            case (step)
                4'd0:    begin a_sel = 2'd1; b_sel = 2'd2; comp = 2'd0; kind = 2'd0; end
                4'd1:    begin a_sel = 2'd2; b_sel = 2'd1; comp = 2'd0; kind = 2'd1; end
                4'd2:    begin a_sel = 2'd2; b_sel = 2'd0; comp = 2'd1; kind = 2'd0; end
                4'd3:    begin a_sel = 2'd0; b_sel = 2'd2; comp = 2'd1; kind = 2'd1; end
                4'd4:    begin a_sel = 2'd0; b_sel = 2'd1; comp = 2'd2; kind = 2'd0; end
                default: begin a_sel = 2'd1; b_sel = 2'd0; comp = 2'd2; kind = 2'd1; end
            endcase
        end else if (state == S_R) begin
            case (step)
                4'd0:    begin a_sel = 2'd3; b_sel = 2'd0; comp = 2'd0; kind = 2'd0; end
                4'd1:    begin a_sel = 2'd1; b_sel = 2'd2; comp = 2'd0; kind = 2'd1; end
                4'd2:    begin a_sel = 2'd2; b_sel = 2'd1; comp = 2'd0; kind = 2'd2; end
                4'd3:    begin a_sel = 2'd3; b_sel = 2'd1; comp = 2'd1; kind = 2'd0; end
                4'd4:    begin a_sel = 2'd2; b_sel = 2'd0; comp = 2'd1; kind = 2'd1; end
                4'd5:    begin a_sel = 2'd0; b_sel = 2'd2; comp = 2'd1; kind = 2'd2; end
                4'd6:    begin a_sel = 2'd3; b_sel = 2'd2; comp = 2'd2; kind = 2'd0; end
                4'd7:    begin a_sel = 2'd0; b_sel = 2'd1; comp = 2'd2; kind = 2'd1; end
                default: begin a_sel = 2'd1; b_sel = 2'd0; comp = 2'd2; kind = 2'd2; end
            endcase
        end
    end

    always_comb begin
        case (a_sel)
            2'd0:    op_a = TW'(u_r[0]);
            2'd1:    op_a = TW'(u_r[1]);
            2'd2:    op_a = TW'(u_r[2]);
            default: op_a = TW'(w_r);
        endcase
        if (state == S_R) begin
            case (b_sel)
                2'd0:    op_b = t_r[0];
                2'd1:    op_b = t_r[1];
                default: op_b = t_r[2];
            endcase
        end else begin
            case (b_sel)
                2'd0:    op_b = TW'(v_r[0]);
                2'd1:    op_b = TW'(v_r[1]);
                default: op_b = TW'(v_r[2]);
            endcase
        end
        case (comp)
            2'd0:    v_pre = AW'(v_r[0]);
            2'd1:    v_pre = AW'(v_r[1]);
            default: v_pre = AW'(v_r[2]);
        endcase
    end

    assign prod    = PW'(op_a) * PW'(op_b);
    assign prod_sh = prod >>> FRAC_BITS;
    assign t_new   = TW'((hold_r - prod_sh) <<< 1);
    assign addend  = AW'(prod_sh);

    // Accumulator wraps at AW bits; first product of a component starts from v[i].
    always_comb begin
        case (kind)
            2'd0:    sum = v_pre + addend;
            2'd1:    sum = acc_r + addend;
            default: sum = acc_r - addend;
        endcase
`ifdef FIXED_QROT_SAT_EN
        if (sum > RES_MAX) begin
            narrowed = TOTAL_PREC'(RES_MAX);
        end else if (sum < RES_MIN) begin
            narrowed = TOTAL_PREC'(RES_MIN);
        end else begin
            narrowed = TOTAL_PREC'(sum);
        end
`else
        narrowed = TOTAL_PREC'(sum);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            step        <= 4'd0;
            w_r         <= '0;
            hold_r      <= '0;
            acc_r       <= '0;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            busy        <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                u_r[i]   <= '0;
                v_r[i]   <= '0;
                t_r[i]   <= '0;
                res_r[i] <= '0;
            end
            stage_r[0] <= '0;
            stage_r[1] <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    in_ready_r <= 1'b1;
                    if (bus.in_valid && in_ready_r) begin
                        for (int i = 0; i < 3; i++) begin
                            u_r[i] <= bus.q[i];
                            v_r[i] <= bus.v[i];
                        end
                        w_r        <= bus.q[3];
                        in_ready_r <= 1'b0;
                        busy       <= 1'b1;
                        step       <= 4'd0;
                        state      <= S_T;
                    end
                end
                S_T: begin
                    if (kind == 2'd0) begin
                        hold_r <= prod_sh;
                    end else begin
                        case (comp)
                            2'd0:    t_r[0] <= t_new;
                            2'd1:    t_r[1] <= t_new;
                            default: t_r[2] <= t_new;
                        endcase
                    end
                    if (step == 4'd5) begin
                        step  <= 4'd0;
                        state <= S_R;
                    end else begin
                        step <= step + 4'd1;
                    end
                end
                S_R: begin
                    acc_r <= sum;
                    if (kind == 2'd2) begin
                        case (comp)
                            2'd0:    stage_r[0] <= narrowed;
                            2'd1:    stage_r[1] <= narrowed;
                            default: begin
                                // Output register only moves on the way into DONE.
                                res_r[0] <= stage_r[0];
                                res_r[1] <= stage_r[1];
                                res_r[2] <= narrowed;
                            end
                        endcase
                    end
                    if (step == 4'd8) begin
                        step        <= 4'd0;
                        out_valid_r <= 1'b1;
                        state       <= S_DONE;
                    end else begin
                        step <= step + 4'd1;
                    end
                end
                default: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        busy        <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state       <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.res[0]    = res_r[0];
    assign bus.res[1]    = res_r[1];
    assign bus.res[2]    = res_r[2];

endmodule
`default_nettype wire
